sub_clause_evaluator: RTL and testbench

Evaluates one sub-clause: a fixed group of up to VAR_PER_CLAUSE literals from a CNF clause. From the current partial assignment it decides whether the sub-clause is a unit clause, and if so which variable is implied and to which value. It sits in the BCP (unit-propagation) datapath, between the clause/variable-state fetch and the implication queue. Outputs are registered, with one-cycle latency.

---
 rtl/sub_clause_evaluator.sv | 156 +++++++++++++++
 tb/tb_sub_clause_evaluator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sub_clause_evaluator.sv
// ----------------------------------------------------------------------------
// sub_clause_evaluator
//
// Purpose:
//   Evaluates one sub-clause (a fixed group of up to VAR_PER_CLAUSE literal
//   slots of a CNF clause) against the current partial assignment. It reports
//   whether the sub-clause is unit and, if so, which variable is implied and
//   the value it must take. Results are registered (one-cycle latency), a new
//   vector is accepted every cycle and there is no backpressure.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   in_valid         in   input vector valid this cycle
//   unassign         in   [VPC]      slot i variable is unassigned
//   clause_mask      in   [VPC]      slot i holds a real literal
//   clause_pole      in   [VPC]      literal polarity (1 = negated literal)
//   val              in   [VPC]      value of slot i variable (when assigned)
//   variable         in   [VPC][MVB] variable index per slot, packed
//   out_valid        out  registered in_valid
//   unit_clause      out  sub-clause is unit
//   implied_variable out  [MVB] variable to imply (0 when not unit)
//   new_val          out  value to assign to implied_variable (0 when not unit)
//
// Optional feature (macro SUB_CLAUSE_STATUS_EN):
//   satisfied        out  at least one masked literal is true
//   conflict         out  no true literal, no free slot, mask non-empty
// ----------------------------------------------------------------------------

`ifndef VAR_PER_CLAUSE
`define VAR_PER_CLAUSE 5
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module sub_clause_evaluator #(
    parameter int VAR_PER_CLAUSE = `VAR_PER_CLAUSE,
    parameter int MAX_VARS_BITS  = `MAX_VARS_BITS
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic                                         in_valid,
    input  logic [VAR_PER_CLAUSE-1:0]                    unassign,
    input  logic [VAR_PER_CLAUSE-1:0]                    clause_mask,
    input  logic [VAR_PER_CLAUSE-1:0]                    clause_pole,
    input  logic [VAR_PER_CLAUSE-1:0]                    val,
    input  logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] variable,
    output logic                                         out_valid,
    output logic                                         unit_clause,
    output logic [MAX_VARS_BITS-1:0]                     implied_variable,
`ifdef SUB_CLAUSE_STATUS_EN
    output logic                                         new_val,
    output logic                                         satisfied,
    output logic                                         conflict
`else
    output logic                                         new_val
`endif
);

    localparam int CNT_W = $clog2(VAR_PER_CLAUSE + 1);

    logic [VAR_PER_CLAUSE-1:0] free_vec;
    logic [VAR_PER_CLAUSE-1:0] true_vec;
    logic                      sat;
    logic [CNT_W-1:0]          nfree;
    logic [MAX_VARS_BITS-1:0]  sel_var;
    logic                      sel_pole;

    logic                      unit_next;
    logic [MAX_VARS_BITS-1:0]  implied_next;
    logic                      new_val_next;

    logic                      out_valid_reg;
    logic                      unit_reg;
    logic [MAX_VARS_BITS-1:0]  implied_reg;
    logic                      new_val_reg;

    // Per-slot classification; empty slots are forced out of both vectors so
    // their unassign/val/pole bits can never influence the result.
    generate
        for (genvar gi = 0; gi < VAR_PER_CLAUSE; gi++) begin : g_slot
            assign free_vec[gi] = clause_mask[gi] & unassign[gi];
            assign true_vec[gi] = clause_mask[gi] & ~unassign[gi]
                                  & (val[gi] ^ clause_pole[gi]);
        end
    endgenerate

    assign sat = |true_vec;

    // Count free slots and OR together the index/polarity of every free slot.
    // The OR only matters when exactly one slot is free, where it reduces to
    // a plain select of that slot, so no priority encoder is needed.
    always_comb begin
        nfree    = '0;
        sel_var  = '0;
        sel_pole = 1'b0;
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            nfree = nfree + CNT_W'(free_vec[i]);
            if (free_vec[i]) begin
                sel_var  = sel_var | variable[i];
                sel_pole = sel_pole | clause_pole[i];
            end
        end
    end

    always_comb begin
        unit_next    = ~sat && (nfree == CNT_W'(1));
        implied_next = unit_next ? sel_var : '0;
        new_val_next = unit_next & ~sel_pole;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            unit_reg      <= 1'b0;
            implied_reg   <= '0;
            new_val_reg   <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                unit_reg    <= unit_next;
                implied_reg <= implied_next;
                new_val_reg <= new_val_next;
            end
        end
    end

    assign out_valid        = out_valid_reg;
    assign unit_clause      = unit_reg;
    assign implied_variable = implied_reg;
    assign new_val          = new_val_reg;

`ifdef SUB_CLAUSE_STATUS_EN
    logic satisfied_reg;
    logic conflict_reg;
    logic conflict_next;

    // An empty sub-clause has no literals at all, so it is not a conflict.
    assign conflict_next = ~sat && (nfree == '0) && (|clause_mask);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            satisfied_reg <= 1'b0;
            conflict_reg  <= 1'b0;
        end else if (in_valid) begin
            satisfied_reg <= sat;
            conflict_reg  <= conflict_next;
        end
    end

    assign satisfied = satisfied_reg;
    assign conflict  = conflict_reg;
`endif

endmodule

// File: tb/tb_sub_clause_evaluator.sv
// ----------------------------------------------------------------------------
// tb_sub_clause_evaluator
//
// Directed-vector bench for sub_clause_evaluator with hand-computed expected
// values. Slot variable indices are fixed: slot0=0x11 .. slot4=0x55.
// ----------------------------------------------------------------------------

module tb_sub_clause_evaluator;

    localparam int VPC = 5;
    localparam int MVB = 8;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic [VPC-1:0]           unassign = '0;
    logic [VPC-1:0]           clause_mask = '0;
    logic [VPC-1:0]           clause_pole = '0;
    logic [VPC-1:0]           val = '0;
    logic [VPC-1:0][MVB-1:0]  variable;
    logic                     out_valid;
    logic                     unit_clause;
    logic [MVB-1:0]           implied_variable;
    logic                     new_val;
`ifdef SUB_CLAUSE_STATUS_EN
    logic                     satisfied;
    logic                     conflict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sub_clause_evaluator #(
        .VAR_PER_CLAUSE (VPC),
        .MAX_VARS_BITS  (MVB)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .unassign         (unassign),
        .clause_mask      (clause_mask),
        .clause_pole      (clause_pole),
        .val              (val),
        .variable         (variable),
        .out_valid        (out_valid),
        .unit_clause      (unit_clause),
        .implied_variable (implied_variable),
`ifdef SUB_CLAUSE_STATUS_EN
        .new_val          (new_val),
        .satisfied        (satisfied),
        .conflict         (conflict)
`else
        .new_val          (new_val)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one vector on the falling edge, then sample #1 after the next
    // rising edge.
    task automatic apply(input string name, input logic iv, input logic [VPC-1:0] ua,
                         input logic [VPC-1:0] m, input logic [VPC-1:0] p,
                         input logic [VPC-1:0] v);
        @(negedge clock);
        in_valid    = iv;
        unassign    = ua;
        clause_mask = m;
        clause_pole = p;
        val         = v;
        @(posedge clock);
        #1;
        $display("txn %-14s iv=%b ua=%b m=%b p=%b v=%b -> ov=%b unit=%b var=0x%02h nv=%b",
                 name, iv, ua, m, p, v, out_valid, unit_clause, implied_variable, new_val);
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic u,
                              input logic [MVB-1:0] iv, input logic nv);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".unit"},      32'(unit_clause), 32'(u));
        check({tag, ".var"},       32'(implied_variable), 32'(iv));
        check({tag, ".new_val"},   32'(new_val), 32'(nv));
    endtask

    initial begin
        variable[0] = 8'h11;
        variable[1] = 8'h22;
        variable[2] = 8'h33;
        variable[3] = 8'h44;
        variable[4] = 8'h55;

        // Reset held with a unit vector presented: everything stays at 0.
        in_valid = 1'b1; unassign = 5'b10000; clause_mask = 5'b11111;
        clause_pole = 5'b00000; val = 5'b00000;
        repeat (3) @(posedge clock);
        #1;
        expect_out("reset", 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef SUB_CLAUSE_STATUS_EN
        check("reset.satisfied", 32'(satisfied), 32'd0);
        check("reset.conflict",  32'(conflict),  32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        apply("empty_mask", 1'b1, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
        expect_out("empty_mask", 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef SUB_CLAUSE_STATUS_EN
        check("empty_mask.conflict", 32'(conflict), 32'd0);
`endif

        apply("unit_pos", 1'b1, 5'b10000, 5'b11111, 5'b00000, 5'b00000);
        expect_out("unit_pos", 1'b1, 1'b1, 8'h55, 1'b1);

        // in_valid low: results hold, out_valid drops, new inputs ignored.
        apply("hold", 1'b0, 5'b11111, 5'b11111, 5'b11111, 5'b00000);
        expect_out("hold", 1'b0, 1'b1, 8'h55, 1'b1);

        apply("unit_neg", 1'b1, 5'b10000, 5'b11111, 5'b10000, 5'b00000);
        expect_out("unit_neg", 1'b1, 1'b1, 8'h55, 1'b0);

        apply("masked_out", 1'b1, 5'b00100, 5'b11110, 5'b00000, 5'b00000);
        expect_out("masked_out", 1'b1, 1'b1, 8'h33, 1'b1);

        // Unmasked slot 0 would be free and true if it counted.
        apply("masked_true", 1'b1, 5'b00101, 5'b11110, 5'b00000, 5'b00001);
        expect_out("masked_true", 1'b1, 1'b1, 8'h33, 1'b1);

        // Free slot 1 carries val=1 (don't-care); negated pole -> implies 0.
        apply("free_val_dc", 1'b1, 5'b00010, 5'b11111, 5'b00010, 5'b00010);
        expect_out("free_val_dc", 1'b1, 1'b1, 8'h22, 1'b0);

        apply("sat_a", 1'b1, 5'b00001, 5'b11111, 5'b00000, 5'b11110);
        expect_out("sat_a", 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef SUB_CLAUSE_STATUS_EN
        check("sat_a.satisfied", 32'(satisfied), 32'd1);
`endif

        apply("unit_slot0", 1'b1, 5'b00001, 5'b11111, 5'b00000, 5'b00000);
        expect_out("unit_slot0", 1'b1, 1'b1, 8'h11, 1'b1);

        apply("sat_b", 1'b1, 5'b00001, 5'b11111, 5'b00000, 5'b00010);
        expect_out("sat_b", 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef SUB_CLAUSE_STATUS_EN
        check("sat_b.satisfied", 32'(satisfied), 32'd1);
        check("sat_b.conflict",  32'(conflict),  32'd0);
`endif

        // Negated literal with value 0 is true: blocks the implication.
        apply("sat_neg", 1'b1, 5'b01000, 5'b11111, 5'b00001, 5'b00000);
        expect_out("sat_neg", 1'b1, 1'b0, 8'h00, 1'b0);

        apply("unit_slot3", 1'b1, 5'b01000, 5'b11111, 5'b00000, 5'b00000);
        expect_out("unit_slot3", 1'b1, 1'b1, 8'h44, 1'b1);

        apply("multi_free", 1'b1, 5'b11111, 5'b11111, 5'b00000, 5'b00000);
        expect_out("multi_free", 1'b1, 1'b0, 8'h00, 1'b0);

        apply("two_free", 1'b1, 5'b00110, 5'b11111, 5'b00000, 5'b00000);
        expect_out("two_free", 1'b1, 1'b0, 8'h00, 1'b0);

        apply("all_false", 1'b1, 5'b00000, 5'b11111, 5'b00000, 5'b00000);
        expect_out("all_false", 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef SUB_CLAUSE_STATUS_EN
        check("all_false.satisfied", 32'(satisfied), 32'd0);
        check("all_false.conflict",  32'(conflict),  32'd1);
`endif

        apply("gap_hold", 1'b0, 5'b10000, 5'b11111, 5'b00000, 5'b00000);
        expect_out("gap_hold", 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset asserted mid-stream: the registered unit result is discarded.
        apply("pre_reset", 1'b1, 5'b10000, 5'b11111, 5'b00000, 5'b00000);
        expect_out("pre_reset", 1'b1, 1'b1, 8'h55, 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        $display("txn %-14s async reset -> ov=%b unit=%b var=0x%02h nv=%b",
                 "mid_reset", out_valid, unit_clause, implied_variable, new_val);
        expect_out("mid_reset", 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        apply("post_reset", 1'b1, 5'b00100, 5'b11111, 5'b00100, 5'b00000);
        expect_out("post_reset", 1'b1, 1'b1, 8'h33, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
